// File: rtl/div16_seq.sv
// Sequential 16-bit restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV16_SIGNED_EN to enable two's-complement division when signed_op=1.
module div16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic        signed_op,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [15:0] q_sh;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [15:0] dvs;
  logic [16:0] prem;

  logic [16:0] shifted;
  logic [17:0] trial;
  logic [16:0] prem_nxt;
  logic [15:0] q_nxt;
  logic [15:0] abs_a;
  logic [15:0] abs_b;
  logic [15:0] q_fin;
  logic [15:0] r_fin;
  logic        unused_prem_msb;

  assign unused_prem_msb = prem[16];

  // bit 17 of the trial sum is the carry out: set when shifted >= dvs
  always_comb begin
    shifted  = {prem[15:0], q_sh[15]};
    trial    = {1'b0, shifted} + {1'b0, ~{1'b0, dvs}} + 18'd1;
    prem_nxt = trial[17] ? trial[16:0] : shifted;
    q_nxt    = {q_sh[14:0], trial[17]};
  end

`ifdef DIV16_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;

  always_comb begin
    a_neg = signed_op & dividend[15];
    b_neg = signed_op & divisor[15];
    abs_a = a_neg ? (~dividend + 16'd1) : dividend;
    abs_b = b_neg ? (~divisor + 16'd1) : divisor;
    q_fin = neg_q ? (~q_nxt + 16'd1) : q_nxt;
    r_fin = neg_r ? (~prem_nxt[15:0] + 16'd1) : prem_nxt[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  always_comb begin
    abs_a = dividend;
    abs_b = divisor;
    q_fin = q_nxt;
    r_fin = prem_nxt[15:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      q_sh      <= 16'h0000;
      dvs       <= 16'h0000;
      prem      <= 17'h00000;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= 16'h0000;
      remainder <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == 16'h0000) begin
              state     <= DONE;
              done      <= 1'b1;
              div_zero  <= 1'b1;
              quotient  <= 16'hFFFF;
              remainder <= dividend;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= 5'd0;
              prem  <= 17'h00000;
              q_sh  <= abs_a;
              dvs   <= abs_b;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          prem <= prem_nxt;
          q_sh <= q_nxt;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            div_zero  <= 1'b0;
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Directed self-checking bench for div16_seq; inputs driven on negedge, outputs sampled on negedge.
module tb_div16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'h0000;
  logic [15:0] divisor = 16'h0000;
  logic        signed_op = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .signed_op(signed_op), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  // Called at a negedge; returns at the negedge just after the accepting edge E0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // cycles = index of the edge after which done was seen (E0 = 0); busy_n = busy samples before done.
  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    int c, b, done_seen;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
    tests++; if (quotient !== 16'h0000) begin fails++; $display("FAIL rst_quot: got %h want 0000", quotient); end
    tests++; if (remainder !== 16'h0000) begin fails++; $display("FAIL rst_rem: got %h want 0000", remainder); end
    tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL rst_dz: got %b want 0", div_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'd100, 16'd10, 1'b0);
    wait_done(c, b);
    tests++; if (quotient !== 16'd10) begin fails++; $display("FAIL pre_rst_quot: got %h want 000a", quotient); end
    @(negedge clk);
    issue(16'd1000, 16'd7, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if (quotient !== 16'h0000) begin fails++; $display("FAIL midrst_quot: got %h want 0000", quotient); end
    tests++; if (remainder !== 16'h0000) begin fails++; $display("FAIL midrst_rem: got %h want 0000", remainder); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    tests++; if (done_seen !== 0) begin fails++; $display("FAIL rst_no_done: got %0d done pulses want 0", done_seen); end
    issue(16'd9, 16'd4, 1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_accept: got busy %b want 1", busy); end
    wait_done(c, b);
    tests++; if (quotient !== 16'd2 || remainder !== 16'd1) begin fails++; $display("FAIL rst_after_op: got %h/%h want 0002/0001", quotient, remainder); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int c, b;
    issue(16'd1000, 16'd7, 1'b0);
    wait_done(c, b);
    tests++; if (c !== 16) begin fails++; $display("FAIL basic_latency: got %0d want 16", c); end
    tests++; if (b !== 16) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 16", b); end
    tests++; if (quotient !== 16'h008E) begin fails++; $display("FAIL basic_quot: got %h want 008e", quotient); end
    tests++; if (remainder !== 16'd6) begin fails++; $display("FAIL basic_rem: got %h want 0006", remainder); end
    tests++; if (div_zero !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_flags: got dz %b busy %b want 0 0", div_zero, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    tests++; if (quotient !== 16'h008E) begin fails++; $display("FAIL basic_hold: got %h want 008e", quotient); end
  endtask

  task automatic test_edges();
    int c, b;
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done(c, b);
    tests++; if (quotient !== 16'hFFFF || remainder !== 16'h0000) begin fails++; $display("FAIL max_div_1: got %h/%h want ffff/0000", quotient, remainder); end
    @(negedge clk);
    issue(16'h0003, 16'hFFFF, 1'b0);
    wait_done(c, b);
    tests++; if (quotient !== 16'h0000 || remainder !== 16'h0003) begin fails++; $display("FAIL small_div_max: got %h/%h want 0000/0003", quotient, remainder); end
    @(negedge clk);
`ifndef DIV16_SIGNED_EN
    issue(16'hFFF9, 16'h0002, 1'b1);
    wait_done(c, b);
    tests++; if (quotient !== 16'h7FFC || remainder !== 16'h0001) begin fails++; $display("FAIL signed_ignored: got %h/%h want 7ffc/0001", quotient, remainder); end
    @(negedge clk);
`endif
  endtask

  task automatic test_div_zero();
    int c, b;
    issue(16'd5, 16'd0, 1'b0);
    wait_done(c, b);
    tests++; if (c !== 0) begin fails++; $display("FAIL dz_latency: got edge %0d want 0", c); end
    tests++; if (b !== 0 || busy !== 1'b0) begin fails++; $display("FAIL dz_busy: got %0d/%b want 0/0", b, busy); end
    tests++; if (quotient !== 16'hFFFF || remainder !== 16'd5) begin fails++; $display("FAIL dz_result: got %h/%h want ffff/0005", quotient, remainder); end
    tests++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL dz_done_pulse: got %b want 0", done); end
    issue(16'd9, 16'd4, 1'b0);
    wait_done(c, b);
    tests++; if (div_zero !== 1'b0 || quotient !== 16'd2) begin fails++; $display("FAIL dz_clear: got dz %b q %h want 0 0002", div_zero, quotient); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c, b;
    dividend = 16'd1000;
    divisor  = 16'd7;
    signed_op = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd10;
    wait_done(c, b);
    tests++; if (c !== 16) begin fails++; $display("FAIL hs_ignore_latency: got %0d want 16", c); end
    tests++; if (quotient !== 16'h008E || remainder !== 16'd6) begin fails++; $display("FAIL hs_ignore_result: got %h/%h want 008e/0006", quotient, remainder); end
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL hs_b2b_accept: got busy %b done %b want 1 0", busy, done); end
    tests++; if (quotient !== 16'h008E) begin fails++; $display("FAIL hs_hold_old: got %h want 008e", quotient); end
    wait_done(c, b);
    tests++; if (c !== 16) begin fails++; $display("FAIL hs_b2b_latency: got %0d want 16", c); end
    tests++; if (quotient !== 16'd10 || remainder !== 16'd0) begin fails++; $display("FAIL hs_b2b_result: got %h/%h want 000a/0000", quotient, remainder); end
    @(negedge clk);
  endtask

`ifdef DIV16_SIGNED_EN
  task automatic test_signed();
    int c, b;
    issue(16'hFFF9, 16'h0002, 1'b1);
    wait_done(c, b);
    tests++; if (c !== 16) begin fails++; $display("FAIL sgn_latency: got %0d want 16", c); end
    tests++; if (quotient !== 16'hFFFD || remainder !== 16'hFFFF) begin fails++; $display("FAIL sgn_m7_2: got %h/%h want fffd/ffff", quotient, remainder); end
    @(negedge clk);
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_done(c, b);
    tests++; if (quotient !== 16'h8000 || remainder !== 16'h0000) begin fails++; $display("FAIL sgn_min_m1: got %h/%h want 8000/0000", quotient, remainder); end
    @(negedge clk);
    issue(16'hFFF9, 16'h0000, 1'b1);
    wait_done(c, b);
    tests++; if (quotient !== 16'hFFFF || remainder !== 16'hFFF9 || div_zero !== 1'b1) begin fails++; $display("FAIL sgn_dz: got %h/%h/%b want ffff/fff9/1", quotient, remainder, div_zero); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
`ifdef DIV16_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
